dly_chain_cal: RTL
==================

Name: dly_chain_cal

Overview:
- Calibration controller for a tapped chain of dlyb delay cells.
- Drives the chain input (LAUNCH → I of the first cell) and captures every cell output (Z of cell k → TAP[k]).
- Measures how many delay cells one CLK period spans, averaged over 2^AVG_LOG2 shots.
- Downstream logic uses the result to select delay taps.

Parameters:
- NTAP, 32: number of delay cells/taps in the chain, ≥2.
- SETTLE, 4: cycles LAUNCH is held low before each shot, ≥3.
- AVG_LOG2, 2: log2 of shots averaged per measurement, 0..4.
- Derived localparam CW = clog2(NTAP+1); CW = 6 at default.

Ports:
- CLK  in  1  rising-edge clock.
- RN  in  1  reset; synchronous, active-low.
- START  in  1  request a measurement; sampled only in IDLE.
- TAP  in  NTAP  raw delay-cell outputs; TAP[0] is nearest LAUNCH; asynchronous to CLK.
- LAUNCH  out  1  registered drive into the chain input.
- BUSY  out  1  measurement in progress.
- DONE  out  1  one-cycle pulse when a measurement ends.
- COUNT  out  CW  averaged tap count; holds its value between DONE pulses.
- SAT  out  1  at least one shot saw all taps high; sticky until the next START.
- ERR  out  1  settle failure or bubble detected; sticky until the next START.

Behaviour:
- Reset: RN = 0 at a CLK edge → state IDLE, all accumulators/counters cleared, LAUNCH = 0, BUSY = 0, DONE = 0, COUNT = 0, SAT = 0, ERR = 0.
  - RN = 0 mid-measurement aborts at once; no DONE pulse.
- Capture path: TAP is sampled into cap1 on every edge, then cap2 on the next edge. Encoding uses cap2 only.
- FSM states: IDLE, ARM, FIRE, HOLD, ENCODE.
- IDLE
  - BUSY = 0.
  - START = 1 → ARM. Clears SAT, ERR, accumulator, shot counter.
  - START while not in IDLE is ignored.
- ARM
  - LAUNCH = 0 for SETTLE cycles.
  - In the last ARM cycle, cap2 must be all-zero.
    - If not: set ERR, go directly to IDLE, pulse DONE; COUNT is left unchanged.
    - Otherwise → FIRE.
- FIRE (1 cycle)
  - LAUNCH = 1 from the edge entering FIRE.
  - The edge leaving FIRE loads cap1 with TAP exactly one CLK period after LAUNCH rose.
- HOLD (1 cycle)
  - LAUNCH = 0; cap2 ← cap1.
- ENCODE (1 cycle)
  - n = number of consecutive ones in cap2 starting at bit 0, range 0..NTAP.
  - Bubble (any 1 above the first 0) → set ERR; n is still the leading-ones count.
  - n == NTAP → set SAT.
  - acc += n. acc is CW+AVG_LOG2 bits wide and cannot overflow.
  - Shot counter increments. If shots < 2^AVG_LOG2 → ARM. Otherwise → IDLE with DONE = 1 and COUNT ← acc >> AVG_LOG2 (truncating).
- BUSY = 1 in every state except IDLE. BUSY = 0 in the cycle DONE is high.
- Latency:
  - First ARM cycle is the cycle after START is sampled.
  - Each shot takes SETTLE+3 cycles.
  - DONE is high exactly 2^AVG_LOG2·(SETTLE+3)+1 cycles after START is sampled; 29 cycles at default.
  - START is accepted again in the DONE cycle; BUSY rises on the following cycle.
- COUNT, SAT and ERR are registered outputs, stable between updates.

Optional Feature:
- Macro DLY_CAL_BUBBLE_FIX_EN.
- Defined:
  - n = popcount(cap2).
  - Bubbles never set ERR; ERR reports settle failure only.
  - SAT still fires when popcount == NTAP.
- Undefined: leading-ones encoding with bubble → ERR, exactly as in Behaviour.
- Ports and timing are identical in both builds.

Test Plan:
- Basic, default params: bench chain model makes TAP = 32'h0000_03FF when sampled one period after LAUNCH rises, for all 4 shots; pulse START → BUSY rises next cycle; DONE pulses 29 cycles after START; COUNT = 10; SAT = 0; ERR = 0; LAUNCH pattern per shot is 4 low, 1 high, 2 low.
- Averaging: per-shot patterns giving 10, 10, 11, 11 → COUNT = 10 (42 >> 2); then patterns giving 12 ×4 on the next START → COUNT = 12.
- Saturation and sticky flags: shot 2 TAP = 32'hFFFF_FFFF (count 32), others count 8 → COUNT = 14 (56 >> 2); SAT = 1. Next START with clean patterns → SAT clears in the cycle after START.
- Bubble: TAP = 32'h0000_05FF on every shot:
  - Macro undefined → COUNT = 9, ERR = 1.
  - Macro defined → COUNT = 10, ERR = 0.
- Settle failure: hold TAP[3] = 1 throughout ARM of shot 1 → DONE at cycle 5 after START; ERR = 1; COUNT keeps its previous value; BUSY = 0 with DONE.
- Reset and ignore: drive RN = 0 for one edge during FIRE of shot 3 → next cycle all outputs zero, no DONE, state IDLE. Separately, START pulsed while BUSY is ignored (DONE timing unchanged from the first START).

Source files
------------

// File: rtl/dly_chain_cal.sv
// Delay-chain calibration: fires LAUNCH into a tapped dlyb chain and counts
// the taps reached in one CLK period, averaged over 2^AVG_LOG2 shots.
// Optional macro DLY_CAL_BUBBLE_FIX_EN: popcount encoding, bubbles tolerated.
module dly_chain_cal #(
    parameter int  NTAP     = 32,
    parameter int  SETTLE   = 4,
    parameter int  AVG_LOG2 = 2,
    localparam int CW       = $clog2(NTAP + 1)
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            START,
    input  logic [NTAP-1:0] TAP,
    output logic            LAUNCH,
    output logic            BUSY,
    output logic            DONE,
    output logic [CW-1:0]   COUNT,
    output logic            SAT,
    output logic            ERR
);

    localparam int AW    = CW + AVG_LOG2;
    localparam int SCW   = $clog2(SETTLE);
    localparam int SHW   = AVG_LOG2 + 1;
    localparam int NSHOT = 1 << AVG_LOG2;

    typedef enum logic [2:0] {IDLE, ARM, FIRE, HOLD, ENCODE} state_t;

    state_t          state, state_n;
    logic [NTAP-1:0] cap1, cap2;
    logic [SCW-1:0]  settle_cnt;
    logic [SHW-1:0]  shot_cnt;
    logic [AW-1:0]   acc, acc_sum;
    logic [CW-1:0]   n;
    logic            bubble;
    logic            settle_last, settle_ok, last_shot;

    assign settle_last = (settle_cnt == SCW'(SETTLE - 1));
    assign settle_ok   = (cap2 == '0);
    assign last_shot   = (shot_cnt == SHW'(NSHOT - 1));
    assign acc_sum     = acc + AW'(n);
    assign BUSY        = (state != IDLE);

`ifdef DLY_CAL_BUBBLE_FIX_EN
    always_comb begin
        n      = '0;
        bubble = 1'b0;
        for (int i = 0; i < NTAP; i++) n = n + CW'(cap2[i]);
    end
`else
    // Leading-ones count from the launch end; any 1 past the first 0 is a bubble.
    logic run;
    always_comb begin
        n      = '0;
        bubble = 1'b0;
        run    = 1'b1;
        for (int i = 0; i < NTAP; i++) begin
            if (!cap2[i])  run    = 1'b0;
            else if (run)  n      = n + CW'(1);
            else           bubble = 1'b1;
        end
    end
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (START) state_n = ARM;
            ARM:     if (settle_last) state_n = settle_ok ? FIRE : IDLE;
            FIRE:    state_n = HOLD;
            HOLD:    state_n = ENCODE;
            ENCODE:  state_n = last_shot ? IDLE : ARM;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state      <= IDLE;
            cap1       <= '0;
            cap2       <= '0;
            settle_cnt <= '0;
            shot_cnt   <= '0;
            acc        <= '0;
            LAUNCH     <= 1'b0;
            DONE       <= 1'b0;
            COUNT      <= '0;
            SAT        <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            state  <= state_n;
            // Two-flop capture: TAP is asynchronous to CLK.
            cap1   <= TAP;
            cap2   <= cap1;
            LAUNCH <= (state_n == FIRE);
            DONE   <= 1'b0;
            settle_cnt <= (state == ARM && state_n == ARM) ? settle_cnt + SCW'(1) : '0;
            case (state)
                IDLE: if (START) begin
                    SAT      <= 1'b0;
                    ERR      <= 1'b0;
                    acc      <= '0;
                    shot_cnt <= '0;
                end
                ARM: if (settle_last && !settle_ok) begin
                    ERR  <= 1'b1;
                    DONE <= 1'b1;
                end
                ENCODE: begin
                    acc      <= acc_sum;
                    shot_cnt <= shot_cnt + SHW'(1);
                    if (bubble)              ERR <= 1'b1;
                    if (n == CW'(NTAP))      SAT <= 1'b1;
                    if (last_shot) begin
                        DONE  <= 1'b1;
                        COUNT <= CW'(acc_sum >> AVG_LOG2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
